video_postproc: RTL and testbench
=================================

VIDEO_POSTPROC -- requirements
Module: video_postproc

Parameters
REQ-001 IN_W, default 8, input colour width per channel; allowed range 4..12.
REQ-002 OUT_W, default 6, output colour width per channel; allowed range 1..IN_W.
REQ-003 DITHER, default 1: 1 = ordered 2x2 dither on width reduction, 0 = truncation; DITHER=1 is legal only when IN_W-OUT_W >= 2.

Interface
REQ-004 clk_sys  in  1  master clock; one clock domain only.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ce_pix  in  1  pixel clock enable; all state advances only on clk_sys edges where ce_pix=1.
REQ-007 scanlines  in  2  dim level: 00 none, 01 25%, 10 50%, 11 75%.
REQ-008 scan_phase  in  1  0 = dim odd lines, 1 = dim even lines.
REQ-009 R, G, B  in  IN_W each  input colour, full-range 0..2^IN_W-1.
REQ-010 HSync, VSync  in  1 each  input sync, positive pulses.
REQ-011 HBlank, VBlank  in  1 each  input blanking, active-high.
REQ-012 VGA_R, VGA_G, VGA_B  out  OUT_W each  processed colour.
REQ-013 VGA_HS, VGA_VS  out  1 each  sync delayed to match colour, active-low.
REQ-014 VGA_DE  out  1  display enable: ~(HBlank|VBlank) delayed to match colour.

Function
REQ-015 Pipeline: 3 stages (S1 capture, S2 dim, S3 dither/quantise); every output appears exactly 3 ce_pix pulses after its input sample; colour, sync and DE stay mutually aligned.
REQ-016 No ce_pix: all registers hold; outputs are static.
REQ-017 Line parity bit lp: toggles on every HSync falling edge detected at S1 (previous sample 1, current sample 0).
REQ-018 VSync falling edge at S1 sets lp to 0 and toggles frame bit fb; when both edges occur on the same sample, the VSync action wins and lp becomes 0, not toggled.
REQ-019 Pixel counter px (1 bit): toggles on every ce_pix; cleared to 0 on HSync falling edge.
REQ-020 Dim is active when scanlines != 0 and (lp XOR scan_phase) = 1; lp and scan_phase are sampled with the pixel at S1.
REQ-021 Dim arithmetic at IN_W bits, each term floored: 25% -> c>>1 + c>>2; 50% -> c>>1; 75% -> c>>2; result never exceeds the input value.
REQ-022 Quantise with DITHER=0: out = c >> (IN_W-OUT_W); when IN_W = OUT_W the value passes through unchanged.
REQ-023 Quantise with DITHER=1: D = IN_W-OUT_W; index i = {lp, px XOR fb}; Bayer value b = {0,2,3,1}[i]; threshold t = b << (D-2); out = min((c + t) >> D, 2^OUT_W-1).
REQ-024 The c + t sum is computed at IN_W+1 bits; wrap-around is forbidden (saturate per REQ-023).
REQ-025 Blank: when DE at S3 = 0, VGA_R/G/B = 0 irrespective of the dim and dither result.
REQ-026 VGA_HS = ~HSync and VGA_VS = ~VSync, each delayed 3 ce_pix; no composite-sync mode.
REQ-027 Colour channels are processed identically and independently.

Reset
REQ-028 While reset=1 (ce_pix ignored): VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_DE=0; lp, fb, px and all edge-detect history = 0; all pipeline stages flushed to blank.
REQ-029 Reset asserted mid-line or mid-frame takes effect on the next clk_sys edge; after release, the first valid output appears on the 3rd ce_pix pulse.

Verification
REQ-030 IN_W=8, OUT_W=6, DITHER=0, scanlines=00, R=0xFF, DE=1 -> VGA_R=63 exactly 3 ce_pix later; with ce_pix gated for 10 clocks, VGA_R holds its value.
REQ-031 scanlines=01, scan_phase=0, R=200, line 1 (lp=1), DITHER=0 -> dimmed 150, VGA_R=37; same input on line 0 -> VGA_R=50.
REQ-032 DITHER=1, R=0xFE, lp=0, fb=0, px=1 (b=2, t=2) -> sum 256 saturates, VGA_R=63, no wrap to 0.
REQ-033 DITHER=1, R=0x01, flat field over 2x2 pixels and two frames -> VGA_R=1 only where b=3, otherwise 0; the pattern shifts horizontally between frames (fb toggles).
REQ-034 HSync and VSync falling on the same sample with lp=1 -> lp=0 and fb toggled; HBlank=1 with R=0xFF -> VGA_R=0 and VGA_DE=0.
REQ-035 reset pulsed mid-frame with outputs non-zero -> next edge gives VGA_R/G/B=0, VGA_HS=VGA_VS=1, VGA_DE=0; after release, the 3-ce_pix latency is restored.

Source files
------------

// File: rtl/video_postproc.sv
`default_nettype none
// ============================================================================
// Module      : video_postproc
// Description : Three-stage pixel post-processor: capture, scanline dimming,
//               ordered 2x2 dither or truncation, blanking and sync delay.
// Revision    : 1.0 - initial release
// ============================================================================
module video_postproc #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 6,
    parameter int DITHER = 1
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic [1:0]       scanlines,
    input  logic             scan_phase,
    input  logic [IN_W-1:0]  R,
    input  logic [IN_W-1:0]  G,
    input  logic [IN_W-1:0]  B,
    input  logic             HSync,
    input  logic             VSync,
    input  logic             HBlank,
    input  logic             VBlank,
    output logic [OUT_W-1:0] VGA_R,
    output logic [OUT_W-1:0] VGA_G,
    output logic [OUT_W-1:0] VGA_B,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_DE
);

    localparam int             c_shift   = IN_W - OUT_W;
    localparam logic [IN_W:0]  c_out_max = {{(IN_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};

    // raster tracking state
    logic hs_prev_q, hs_prev_d;
    logic vs_prev_q, vs_prev_d;
    logic lp_q, lp_d;
    logic fb_q, fb_d;
    logic px_q, px_d;

    // S1 capture
    logic [IN_W-1:0] c1_q [3];
    logic [IN_W-1:0] c1_d [3];
    logic            hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d, dim1_q, dim1_d;
    logic [1:0]      lvl1_q, lvl1_d, idx1_q, idx1_d;

    // S2 dim
    logic [IN_W-1:0] c2_q [3];
    logic [IN_W-1:0] c2_d [3];
    logic            hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;
    logic [1:0]      idx2_q, idx2_d;

    // S3 output
    logic [OUT_W-1:0] rgb3_q [3];
    logic [OUT_W-1:0] rgb3_d [3];
    logic             vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d, vga_de_q, vga_de_d;

    logic             w_hs_fall, w_vs_fall;
    logic [IN_W:0]    w_thr;
    logic [IN_W:0]    w_sum [3];
    logic [IN_W:0]    w_lvl [3];

    generate
        if (DITHER != 0) begin : g_dither
            logic [1:0] w_bayer;
            always_comb begin
                case (idx2_q)
                    2'd0:    w_bayer = 2'd0;
                    2'd1:    w_bayer = 2'd2;
                    2'd2:    w_bayer = 2'd3;
                    default: w_bayer = 2'd1;
                endcase
            end
            assign w_thr = {{(IN_W - 1){1'b0}}, w_bayer} << (c_shift - 2);
        end else begin : g_trunc
            assign w_thr = '0;
        end
    endgenerate

    always_comb begin
        w_hs_fall = hs_prev_q & ~HSync;
        w_vs_fall = vs_prev_q & ~VSync;
        hs_prev_d = HSync;
        vs_prev_d = VSync;
        lp_d      = lp_q;
        fb_d      = fb_q;
        px_d      = w_hs_fall ? 1'b0 : ~px_q;
        // a frame start overrides the line toggle on a shared sample
        if (w_vs_fall) begin
            lp_d = 1'b0;
            fb_d = ~fb_q;
        end else if (w_hs_fall) begin
            lp_d = ~lp_q;
        end

        c1_d[0] = R;
        c1_d[1] = G;
        c1_d[2] = B;
        hs1_d   = HSync;
        vs1_d   = VSync;
        de1_d   = ~(HBlank | VBlank);
        dim1_d  = (scanlines != 2'b00) & (lp_d ^ scan_phase);
        lvl1_d  = scanlines;
        idx1_d  = {lp_d, px_d ^ fb_d};

        hs2_d  = hs1_q;
        vs2_d  = vs1_q;
        de2_d  = de1_q;
        idx2_d = idx1_q;
        for (int i = 0; i < 3; i++) begin
            c2_d[i] = c1_q[i];
            if (dim1_q) begin
                case (lvl1_q)
                    2'b01:   c2_d[i] = (c1_q[i] >> 1) + (c1_q[i] >> 2);
                    2'b10:   c2_d[i] = c1_q[i] >> 1;
                    default: c2_d[i] = c1_q[i] >> 2;
                endcase
            end
        end

        vga_hs_d = ~hs2_q;
        vga_vs_d = ~vs2_q;
        vga_de_d = de2_q;
        // sum carries an extra bit so the threshold can never wrap the colour
        for (int i = 0; i < 3; i++) begin
            w_sum[i]  = {1'b0, c2_q[i]} + w_thr;
            w_lvl[i]  = w_sum[i] >> c_shift;
            rgb3_d[i] = '0;
            if (de2_q) begin
                rgb3_d[i] = (w_lvl[i] > c_out_max) ? c_out_max[OUT_W-1:0]
                                                   : w_lvl[i][OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            lp_q      <= 1'b0;
            fb_q      <= 1'b0;
            px_q      <= 1'b0;
            c1_q      <= '{default: '0};
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            de1_q     <= 1'b0;
            dim1_q    <= 1'b0;
            lvl1_q    <= 2'b00;
            idx1_q    <= 2'b00;
            c2_q      <= '{default: '0};
            hs2_q     <= 1'b0;
            vs2_q     <= 1'b0;
            de2_q     <= 1'b0;
            idx2_q    <= 2'b00;
            rgb3_q    <= '{default: '0};
            vga_hs_q  <= 1'b1;
            vga_vs_q  <= 1'b1;
            vga_de_q  <= 1'b0;
        end else if (ce_pix) begin
            hs_prev_q <= hs_prev_d;
            vs_prev_q <= vs_prev_d;
            lp_q      <= lp_d;
            fb_q      <= fb_d;
            px_q      <= px_d;
            c1_q      <= c1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            de1_q     <= de1_d;
            dim1_q    <= dim1_d;
            lvl1_q    <= lvl1_d;
            idx1_q    <= idx1_d;
            c2_q      <= c2_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
            de2_q     <= de2_d;
            idx2_q    <= idx2_d;
            rgb3_q    <= rgb3_d;
            vga_hs_q  <= vga_hs_d;
            vga_vs_q  <= vga_vs_d;
            vga_de_q  <= vga_de_d;
        end
    end

    assign VGA_R  = rgb3_q[0];
    assign VGA_G  = rgb3_q[1];
    assign VGA_B  = rgb3_q[2];
    assign VGA_HS = vga_hs_q;
    assign VGA_VS = vga_vs_q;
    assign VGA_DE = vga_de_q;

endmodule
`default_nettype wire

// File: tb/tb_video_postproc.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_postproc
// Description : Bench for video_postproc, dithered and truncating instances
//               against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_postproc;

    typedef struct packed {
        logic       rst, ce;
        logic [1:0] sl;
        logic       sp;
        logic [7:0] r, g, b;
        logic       hs, vs, hb, vb;
    } smp_t;

    typedef struct packed {
        logic [5:0] tr, tg, tb, dr, dg, db;
        logic       hsn, vsn, de;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1, ce_pix = 1'b0, scan_phase = 1'b0;
    logic [1:0] scanlines = 2'b00;
    logic [7:0] R = '0, G = '0, B = '0;
    logic       HSync = 1'b0, VSync = 1'b0, HBlank = 1'b0, VBlank = 1'b0;
    logic [5:0] d_r, d_g, d_b, t_r, t_g, t_b;
    logic       d_hs, d_vs, d_de, t_hs, t_vs, t_de;

    int   total = 0, bad = 0;
    logic chk_en = 1'b0;

    int   m_lp = 0, m_fb = 0, m_px = 0, m_hsp = 0, m_vsp = 0;
    int   bayer [4] = '{0, 2, 3, 1};
    exp_t pipe [$];
    exp_t e_now;

    video_postproc #(.IN_W(8), .OUT_W(6), .DITHER(1)) dut_d (
        .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .scanlines(scanlines),
        .scan_phase(scan_phase), .R(R), .G(G), .B(B), .HSync(HSync), .VSync(VSync),
        .HBlank(HBlank), .VBlank(VBlank), .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b),
        .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_DE(d_de)
    );

    video_postproc #(.IN_W(8), .OUT_W(6), .DITHER(0)) dut_t (
        .clk_sys(clk), .reset(reset), .ce_pix(ce_pix), .scanlines(scanlines),
        .scan_phase(scan_phase), .R(R), .G(G), .B(B), .HSync(HSync), .VSync(VSync),
        .HBlank(HBlank), .VBlank(VBlank), .VGA_R(t_r), .VGA_G(t_g), .VGA_B(t_b),
        .VGA_HS(t_hs), .VGA_VS(t_vs), .VGA_DE(t_de)
    );

    initial forever #5 clk = ~clk;

    function automatic exp_t blank_e();
        exp_t e;
        e     = '0;
        e.hsn = 1'b1;
        e.vsn = 1'b1;
        return e;
    endfunction

    function automatic int dimv(input int c, input int sl, input bit on);
        if (!on || sl == 0) return c;
        if (sl == 1) return c / 2 + c / 4;
        if (sl == 2) return c / 2;
        return c / 4;
    endfunction

    function automatic int quant(input int c, input int t);
        int v;
        v = (c + t) / 4;
        return (v > 63) ? 63 : v;
    endfunction

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    // one clk_sys cycle: drive at negedge, advance the model at posedge
    task automatic pix(input smp_t s);
        exp_t e;
        int   ch_in [3];
        int   dc, bay;
        bit   hf, vf, on, de;
        @(negedge clk);
        reset = s.rst; ce_pix = s.ce; scanlines = s.sl; scan_phase = s.sp;
        R = s.r; G = s.g; B = s.b;
        HSync = s.hs; VSync = s.vs; HBlank = s.hb; VBlank = s.vb;
        @(posedge clk);
        if (s.rst) begin
            m_lp = 0; m_fb = 0; m_px = 0; m_hsp = 0; m_vsp = 0;
            pipe.delete();
            pipe.push_back(blank_e());
            pipe.push_back(blank_e());
            e_now = blank_e();
        end else if (s.ce) begin
            hf = (m_hsp == 1) && !s.hs;
            vf = (m_vsp == 1) && !s.vs;
            if (vf) begin
                m_lp = 0;
                m_fb = 1 - m_fb;
            end else if (hf) begin
                m_lp = 1 - m_lp;
            end
            m_px  = hf ? 0 : 1 - m_px;
            m_hsp = s.hs;
            m_vsp = s.vs;
            de  = !(s.hb || s.vb);
            on  = (s.sl != 0) && ((m_lp ^ int'(s.sp)) == 1);
            bay = bayer[m_lp * 2 + (m_px ^ m_fb)];
            ch_in[0] = s.r; ch_in[1] = s.g; ch_in[2] = s.b;
            e = '0;
            for (int k = 0; k < 3; k++) begin
                dc = dimv(ch_in[k], s.sl, on);
                case (k)
                    0: begin e.tr = de ? 6'(dc / 4) : 6'd0; e.dr = de ? 6'(quant(dc, bay)) : 6'd0; end
                    1: begin e.tg = de ? 6'(dc / 4) : 6'd0; e.dg = de ? 6'(quant(dc, bay)) : 6'd0; end
                    default: begin e.tb = de ? 6'(dc / 4) : 6'd0; e.db = de ? 6'(quant(dc, bay)) : 6'd0; end
                endcase
            end
            e.hsn = !s.hs;
            e.vsn = !s.vs;
            e.de  = de;
            pipe.push_back(e);
            e_now = pipe.pop_front();
        end
        #1;
    endtask

    initial begin
        e_now = blank_e();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                total++;
                if ({t_r, t_g, t_b, t_hs, t_vs, t_de} !== {e_now.tr, e_now.tg, e_now.tb, e_now.hsn, e_now.vsn, e_now.de}) begin
                    bad++;
                    $display("FAIL trunc_out @%0t: got %h %h %h hs%b vs%b de%b want %h %h %h hs%b vs%b de%b",
                             $time, t_r, t_g, t_b, t_hs, t_vs, t_de,
                             e_now.tr, e_now.tg, e_now.tb, e_now.hsn, e_now.vsn, e_now.de);
                end
                total++;
                if ({d_r, d_g, d_b, d_hs, d_vs, d_de} !== {e_now.dr, e_now.dg, e_now.db, e_now.hsn, e_now.vsn, e_now.de}) begin
                    bad++;
                    $display("FAIL dither_out @%0t: got %h %h %h hs%b vs%b de%b want %h %h %h hs%b vs%b de%b",
                             $time, d_r, d_g, d_b, d_hs, d_vs, d_de,
                             e_now.dr, e_now.dg, e_now.db, e_now.hsn, e_now.vsn, e_now.de);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        smp_t s;
        // reset state
        s = '0; s.rst = 1'b1; s.ce = 1'b1; s.r = 8'hFF;
        pix(s);
        chk_en = 1'b1;
        pix(s); pix(s);
        chk("rst_r", int'(t_r), 0);
        chk("rst_hs", int'(t_hs), 1);
        chk("rst_vs", int'(t_vs), 1);
        chk("rst_de", int'(t_de), 0);

        // latency and hold
        s = '0; s.ce = 1'b1;
        pix(s); pix(s); pix(s);
        s.r = 8'hFF; s.g = 8'h80; s.b = 8'h04;
        pix(s);
        s.r = 8'h00; s.g = 8'h00; s.b = 8'h00;
        pix(s);
        chk("lat_2", int'(t_r), 0);
        pix(s);
        chk("lat_3_r", int'(t_r), 63);
        chk("lat_3_g", int'(t_g), 32);
        chk("lat_3_b", int'(t_b), 1);
        s.ce = 1'b0;
        repeat (10) begin
            s.r = 8'($urandom);
            pix(s);
        end
        chk("hold_r", int'(t_r), 63);
        s.ce = 1'b1; s.r = 8'h00;

        // scanline dim on line 1 then line 0
        s.sl = 2'b01; s.sp = 1'b0;
        s.hb = 1'b1; s.hs = 1'b1; pix(s);
        s.hs = 1'b0; pix(s);
        s.hb = 1'b0; s.r = 8'd200;
        pix(s); pix(s); pix(s);
        chk("dim_line1", int'(t_r), 37);
        s.hb = 1'b1; s.hs = 1'b1; pix(s);
        s.hs = 1'b0; pix(s);
        s.hb = 1'b0;
        pix(s); pix(s); pix(s);
        chk("dim_line0", int'(t_r), 50);

        // mid-frame reset, then saturation on the first pixel after release
        s.rst = 1'b1; s.ce = 1'b0; pix(s);
        chk("mid_rst_r", int'(t_r), 0);
        chk("mid_rst_dr", int'(d_r), 0);
        chk("mid_rst_hs", int'(t_hs), 1);
        chk("mid_rst_de", int'(t_de), 0);
        s.rst = 1'b0; s.ce = 1'b1; s.sl = 2'b00; s.r = 8'hFE;
        pix(s);
        s.r = 8'h00;
        pix(s);
        chk("rel_2", int'(d_r), 0);
        pix(s);
        chk("sat_dither", int'(d_r), 63);
        chk("rel_trunc", int'(t_r), 63);
        chk("rel_de", int'(d_de), 1);

        // flat R=1 dither pattern over two frames
        s.r = 8'd1; s.g = 8'd1; s.b = 8'd1;
        for (int f = 0; f < 2; f++) begin
            s.hb = 1'b1; s.vb = 1'b1; s.vs = 1'b1; pix(s);
            s.vs = 1'b0; pix(s);
            s.hs = 1'b1; pix(s);
            s.hs = 1'b0; s.hb = 1'b0; s.vb = 1'b0; pix(s);
            pix(s); pix(s);
            chk(f == 0 ? "f1_p0" : "f2_p0", int'(d_r), f == 0 ? 0 : 1);
            pix(s);
            chk(f == 0 ? "f1_p1" : "f2_p1", int'(d_r), f == 0 ? 1 : 0);
        end

        // HSync and VSync falling together with lp=1
        s.hb = 1'b1; s.hs = 1'b1; s.vs = 1'b1; pix(s);
        s.hs = 1'b0; s.vs = 1'b0; s.hb = 1'b0; s.r = 8'd2; pix(s);
        pix(s); pix(s);
        chk("both_fall", int'(d_r), 1);
        s.hb = 1'b1; s.r = 8'hFF;
        pix(s); pix(s); pix(s);
        chk("hblank_r", int'(t_r), 0);
        chk("hblank_dr", int'(d_r), 0);
        chk("hblank_de", int'(t_de), 0);

        // randomized traffic
        repeat (4000) begin
            s.rst = ($urandom_range(0, 299) == 0);
            s.ce  = ($urandom_range(0, 3) != 0);
            s.sl  = 2'($urandom);
            s.sp  = ($urandom_range(0, 15) == 0) ? ~s.sp : s.sp;
            s.r   = ($urandom_range(0, 3) == 0) ? (8'hFC | 8'($urandom_range(0, 3))) : 8'($urandom);
            s.g   = 8'($urandom);
            s.b   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            s.hs  = ($urandom_range(0, 11) == 0);
            s.vs  = ($urandom_range(0, 47) == 0) ? 1'b1 : (s.vs & ($urandom_range(0, 1) == 0));
            s.hb  = ($urandom_range(0, 7) == 0);
            s.vb  = ($urandom_range(0, 15) == 0);
            pix(s);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
